// File: rtl/z8_program_loader.sv
// z8_program_loader
//   Decodes a framed byte stream into 24-bit z8 instruction words and writes
//   them into instruction memory. The core is held in reset until a frame
//   with legal opcodes, a legal length and a matching checksum has loaded.
//
//   Frame: HDR_BYTE, N, N x {opcode, operand_a, operand_b}, checksum
//   checksum = XOR of N and all 3N instruction bytes.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   rx_data/valid    incoming byte stream
//   rx_ready         byte accepted when rx_valid && rx_ready
//   imem_we/addr/    one-cycle instruction memory write
//   imem_wdata         {opcode, operand_a, operand_b}
//   core_rst_hold    high holds the core in reset
//   load_done        last frame loaded successfully (level)
//   load_error       last frame rejected (level)
//   error_code       00 none, 01 illegal opcode, 10 bad length, 11 checksum
module z8_program_loader #(
   parameter int          IMEM_DEPTH = 256,
   parameter int          ADDR_W     = 8,
   parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [23:0]       imem_wdata,
   output logic              core_rst_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [1:0]        error_code
);

   // One extra bit so a full IMEM_DEPTH-word count never wraps.
   localparam int CW = ADDR_W + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LEN, S_OPC, S_OPA, S_OPB, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
   logic [7:0]      csum_q, csum_d, opc_q, opc_d, opa_q, opa_d, opb_q, opb_d;
   logic            hold_q, hold_d, done_q, done_d, err_q, err_d;
   logic [1:0]      code_q, code_d;
   logic            xfer, opc_legal;

   assign rx_ready   = (state_q != S_WRITE) && !rst;
   assign xfer       = rx_valid && rx_ready;
   assign cnt_inc    = cnt_q + CW'(1);
   assign opc_legal  = (rx_data <= 8'h1E) || (rx_data == 8'hFE);

   assign imem_we       = (state_q == S_WRITE) && !rst;
   assign imem_addr     = cnt_q[ADDR_W-1:0];
   assign imem_wdata    = {opc_q, opa_q, opb_q};
   assign core_rst_hold = hold_q;
   assign load_done     = done_q;
   assign load_error    = err_q;
   assign error_code    = code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         opc_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         opc_q   <= opc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      opc_d   = opc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      case (state_q)
         // Waiting for a header; anything else is dropped without effect.
         S_IDLE, S_DONE, S_ERROR: begin
            if (xfer && rx_data == HDR_BYTE) begin
               state_d = S_LEN;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               code_d  = 2'b00;
               csum_d  = '0;
               cnt_d   = '0;
            end
         end
         S_LEN: begin
            if (xfer) begin
               if (rx_data == 8'h00 || int'(rx_data) > IMEM_DEPTH) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = 2'b10;
               end else begin
                  len_d   = CW'(rx_data);
                  csum_d  = csum_q ^ rx_data;
                  state_d = S_OPC;
               end
            end
         end
         S_OPC: begin
            if (xfer) begin
               if (opc_legal) begin
                  opc_d   = rx_data;
                  csum_d  = csum_q ^ rx_data;
                  state_d = S_OPA;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = 2'b01;
               end
            end
         end
         S_OPA: begin
            if (xfer) begin
               opa_d   = rx_data;
               csum_d  = csum_q ^ rx_data;
               state_d = S_OPB;
            end
         end
         S_OPB: begin
            if (xfer) begin
               opb_d   = rx_data;
               csum_d  = csum_q ^ rx_data;
               state_d = S_WRITE;
            end
         end
         // Write strobe is decoded from this state; rx_ready is low here.
         S_WRITE: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? S_CSUM : S_OPC;
         end
         S_CSUM: begin
            if (xfer) begin
               if (rx_data == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = 2'b11;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_z8_program_loader.sv
module tb_z8_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   // Default instance (IMEM_DEPTH=256)
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready, imem_we, core_rst_hold, load_done, load_error;
   logic [7:0]  imem_addr;
   logic [23:0] imem_wdata;
   logic [1:0]  error_code;
   // Small instance (IMEM_DEPTH=4, ADDR_W=2)
   logic [7:0]  rx_data2 = '0;
   logic        rx_valid2 = 1'b0;
   logic        rx_ready2, imem_we2, core_rst_hold2, load_done2, load_error2;
   logic [1:0]  imem_addr2;
   logic [23:0] imem_wdata2;
   logic [1:0]  error_code2;

   int checks = 0;
   int fails  = 0;
   int nrdy   = 0;
   int wa[$], wa2[$];
   logic [23:0] wd[$], wd2[$];

   z8_program_loader dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst_hold(core_rst_hold),
      .load_done(load_done), .load_error(load_error), .error_code(error_code)
   );

   z8_program_loader #(.IMEM_DEPTH(4), .ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_valid(rx_valid2),
      .rx_ready(rx_ready2), .imem_we(imem_we2), .imem_addr(imem_addr2),
      .imem_wdata(imem_wdata2), .core_rst_hold(core_rst_hold2),
      .load_done(load_done2), .load_error(load_error2), .error_code(error_code2)
   );

   always #5 clk = ~clk;

   // Record writes and count not-ready cycles mid-cycle, away from the edge.
   always @(negedge clk) begin
      if (imem_we) begin wa.push_back(int'(imem_addr)); wd.push_back(imem_wdata); end
      if (imem_we2) begin wa2.push_back(int'(imem_addr2)); wd2.push_back(imem_wdata2); end
      if (!rx_ready && !rst) nrdy++;
   end

   task automatic send(input bit s, input logic [7:0] b);
      int n = 0;
      if (s) begin rx_data2 = b; rx_valid2 = 1'b1; end
      else   begin rx_data  = b; rx_valid  = 1'b1; end
      while (!(s ? rx_ready2 : rx_ready) && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin
         checks++; fails++;
         $display("FAIL send_timeout: rx_ready stayed 0 for byte %02h, required 1", b);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_valid2 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_mon();
      wa.delete(); wd.delete(); wa2.delete(); wd2.delete(); nrdy = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(3);
      checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", rx_ready); end
      checks++;
      if ({imem_we, imem_addr, imem_wdata, core_rst_hold, load_done, load_error, error_code} !== {1'b0, 8'h00, 24'h0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
         fails++; $display("FAIL rst_outs: we=%b a=%h d=%h hold=%b done=%b err=%b code=%b want 0 0 0 1 0 0 00",
            imem_we, imem_addr, imem_wdata, core_rst_hold, load_done, load_error, error_code);
      end
      rst = 1'b0; idle(1);
      checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", rx_ready); end
   endtask

   task automatic test_single_word();
      logic [7:0] f [6] = '{8'hA5, 8'h01, 8'h1A, 8'h03, 8'h00, 8'h18};
      clear_mon();
      foreach (f[i]) send(0, f[i]);
      checks++;
      if (wa.size() != 1 || wa[0] != 0 || wd[0] !== 24'h1A0300) begin
         fails++; $display("FAIL single_write: n=%0d a=%0d d=%h want 1 0 1a0300", wa.size(),
            wa.size() ? wa[0] : -1, wd.size() ? wd[0] : 24'hx);
      end
      checks++;
      if ({load_done, core_rst_hold, load_error, error_code} !== 5'b10000) begin
         fails++; $display("FAIL single_done: done=%b hold=%b err=%b code=%b want 1 0 0 00",
            load_done, core_rst_hold, load_error, error_code);
      end
   endtask

   // Two words with a gap after every byte; checksum 02^03^01^2A^FE^00^00 = D4.
   task automatic test_gaps_two_words();
      logic [7:0] f [9] = '{8'hA5, 8'h02, 8'h03, 8'h01, 8'h2A, 8'hFE, 8'h00, 8'h00, 8'hD4};
      clear_mon();
      checks++; if (core_rst_hold !== 1'b0) begin fails++; $display("FAIL pre_hold: got %b want 0", core_rst_hold); end
      send(0, f[0]);
      checks++; if (core_rst_hold !== 1'b1 || load_done !== 1'b0) begin
         fails++; $display("FAIL rehold: hold=%b done=%b want 1 0", core_rst_hold, load_done); end
      for (int i = 1; i < 9; i++) begin idle(1); send(0, f[i]); end
      checks++;
      if (wa.size() != 2 || wa[0] != 0 || wd[0] !== 24'h03012A || wa[1] != 1 || wd[1] !== 24'hFE0000) begin
         fails++; $display("FAIL two_writes: n=%0d want 2 writes 03012a@0 fe0000@1", wa.size());
      end
      checks++; if (nrdy != 2) begin fails++; $display("FAIL ready_low: got %0d cycles want 2", nrdy); end
      checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL two_done: got %b want 1", load_done); end
   endtask

   task automatic test_illegal_opcode();
      logic [7:0] f [6] = '{8'hA5, 8'h01, 8'h1A, 8'h03, 8'h00, 8'h18};
      clear_mon();
      send(0, 8'hA5); send(0, 8'h01); send(0, 8'h40);
      checks++;
      if ({load_error, error_code, core_rst_hold, load_done} !== 5'b10110) begin
         fails++; $display("FAIL illegal_opc: err=%b code=%b hold=%b done=%b want 1 01 1 0",
            load_error, error_code, core_rst_hold, load_done);
      end
      send(0, 8'h00); send(0, 8'h00);
      checks++;
      if (wa.size() != 0 || load_error !== 1'b1 || error_code !== 2'b01) begin
         fails++; $display("FAIL err_hold: writes=%0d err=%b code=%b want 0 1 01", wa.size(), load_error, error_code);
      end
      foreach (f[i]) send(0, f[i]);
      checks++;
      if ({load_done, load_error, error_code, core_rst_hold} !== 5'b10000 || wd.size() != 1) begin
         fails++; $display("FAIL recover: done=%b err=%b code=%b hold=%b writes=%0d want 1 0 00 0 1",
            load_done, load_error, error_code, core_rst_hold, wd.size());
      end
   endtask

   task automatic test_bad_length();
      clear_mon();
      send(0, 8'hA5); send(0, 8'h00);
      checks++; if (load_error !== 1'b1 || error_code !== 2'b10) begin
         fails++; $display("FAIL len_zero: err=%b code=%b want 1 10", load_error, error_code); end
      send(1, 8'hA5); send(1, 8'h05);
      checks++; if (load_error2 !== 1'b1 || error_code2 !== 2'b10) begin
         fails++; $display("FAIL len_over: err=%b code=%b want 1 10", load_error2, error_code2); end
      idle(2);
      checks++; if (wa.size() != 0 || wa2.size() != 0) begin
         fails++; $display("FAIL len_writes: got %0d/%0d want 0/0", wa.size(), wa2.size()); end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] f [6] = '{8'hA5, 8'h01, 8'h1A, 8'h03, 8'h00, 8'h19};
      clear_mon();
      foreach (f[i]) send(0, f[i]);
      checks++; if (wd.size() != 1 || wd[0] !== 24'h1A0300) begin
         fails++; $display("FAIL csum_write: n=%0d want 1 write 1a0300", wd.size()); end
      checks++;
      if ({load_error, error_code, core_rst_hold, load_done} !== 5'b11110) begin
         fails++; $display("FAIL csum_err: err=%b code=%b hold=%b done=%b want 1 11 1 0",
            load_error, error_code, core_rst_hold, load_done);
      end
   endtask

   task automatic test_reset_mid_frame();
      send(0, 8'hA5); send(0, 8'h03); send(0, 8'h01);   // now expecting operand_a
      rst = 1'b1; idle(1);
      checks++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst_hold, load_done, load_error, error_code} !==
          {1'b0, 1'b0, 8'h00, 24'h0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
         fails++; $display("FAIL mid_rst: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b code=%b want reset values",
            rx_ready, imem_we, imem_addr, imem_wdata, core_rst_hold, load_done, load_error, error_code);
      end
      rst = 1'b0; idle(1);
   endtask

   // Full IMEM_DEPTH=4 load; checksum of 04 and the 12 bytes below is 92.
   task automatic test_full_depth();
      logic [7:0]  f [15] = '{8'hA5, 8'h04, 8'h01, 8'h11, 8'h22, 8'h02, 8'h33, 8'h44,
                              8'h03, 8'h55, 8'h66, 8'h1E, 8'h77, 8'h88, 8'h92};
      logic [23:0] exp [4] = '{24'h011122, 24'h023344, 24'h035566, 24'h1E7788};
      clear_mon();
      foreach (f[i]) send(1, f[i]);
      checks++; if (wa2.size() != 4) begin fails++; $display("FAIL full_count: got %0d want 4", wa2.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa2[i] != i || wd2[i] !== exp[i]) begin
               fails++; $display("FAIL full_word%0d: a=%0d d=%h want %0d %h", i, wa2[i], wd2[i], i, exp[i]);
            end
         end
      end
      checks++; if (load_done2 !== 1'b1 || core_rst_hold2 !== 1'b0) begin
         fails++; $display("FAIL full_done: done=%b hold=%b want 1 0", load_done2, core_rst_hold2); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_gaps_two_words();
      test_illegal_opcode();
      test_bad_length();
      test_bad_checksum();
      test_reset_mid_frame();
      test_full_depth();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
